// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared core types and constants used by the fetch queue and decode
package cpu_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  // ADDI x0,x0,0: the bubble word the whole core uses
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - fetch/decode handshake bundle for inst_fetch_queue
interface inst_fetch_queue_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [31:0]   fetch_inst;
  logic          fetch_ready;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic          id_ready;
  logic          flush;
  logic [CW-1:0] count;

  // master drives fetch data, decode readiness and flush; the queue is the slave
  modport master (
    output fetch_valid, fetch_pc, fetch_inst, id_ready, flush,
    input  fetch_ready, id_valid, id_pc, id_inst, count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst, id_ready, flush,
    output fetch_ready, id_valid, id_pc, id_inst, count
  );

endinterface

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - DEPTH x 64-bit entry array, one write port, async read
module ifq_storage
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [PW-1:0] i_wr_ptr,
  input  ifq_entry_t    i_wr_data,
  input  logic [PW-1:0] i_rd_ptr,
  output ifq_entry_t    o_rd_data
);

  // no reset: validity is tracked by the occupancy count alone
  ifq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch-to-decode instruction queue; IFQ_BYPASS_EN enables empty-queue bypass
module inst_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input logic                 clk,
  input logic                 rst,
  inst_fetch_queue_if.slave   ifq_bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic       w_empty;
  logic       w_full;
  logic       w_fetch_ready;
  logic       w_bypass;
  logic       w_push;
  logic       w_pop;
  ifq_entry_t w_wr_data;
  ifq_entry_t w_head;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CW'(DEPTH));
  assign w_fetch_ready = !w_full && !rst;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_empty && ifq_bus.fetch_valid && w_fetch_ready &&
                    ifq_bus.id_ready && !ifq_bus.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // a bypassed word goes straight to decode and is never stored
  assign w_push = ifq_bus.fetch_valid && w_fetch_ready && !ifq_bus.flush && !w_bypass;
  assign w_pop  = !w_empty && ifq_bus.id_ready && !ifq_bus.flush;

  assign w_wr_data.pc   = ifq_bus.fetch_pc;
  assign w_wr_data.inst = ifq_bus.fetch_inst;

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (w_wr_data),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_head)
  );

  always_ff @(posedge clk) begin
    if (rst || ifq_bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    ifq_bus.id_pc   = 32'h0;
    ifq_bus.id_inst = NOP_INST;
    if (w_bypass) begin
      ifq_bus.id_pc   = ifq_bus.fetch_pc;
      ifq_bus.id_inst = ifq_bus.fetch_inst;
    end else if (!w_empty) begin
      ifq_bus.id_pc   = w_head.pc;
      ifq_bus.id_inst = w_head.inst;
    end
  end

  assign ifq_bus.id_valid    = !w_empty || w_bypass;
  assign ifq_bus.fetch_ready = w_fetch_ready;
  assign ifq_bus.count       = r_count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue (DEPTH=2)
module tb_inst_fetch_queue;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.DEPTH(2)) bus ();

  inst_fetch_queue #(
    .DEPTH    (2),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ifq_bus (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
    bus.fetch_inst  = pc ^ 32'hA5A5_0000;
  endtask

  logic [31:0] q[$];
  logic [31:0] popped[$];
  int          next_k;
  logic        acc, pop;

  initial begin
    rst = 1'b1;
    offer(1'b0, 32'h0);
    bus.id_ready = 1'b0;
    bus.flush    = 1'b0;

    cyc();
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    check("rst_id_valid",    32'(bus.id_valid),    32'd0);
    check("rst_id_inst",     bus.id_inst,          32'h0000_0013);
    check("rst_id_pc",       bus.id_pc,            32'h0);
    check("rst_count",       32'(bus.count),       32'd0);
    rst = 1'b0;
    #1;
    check("idle_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    cyc();
    check("idle_id_valid", 32'(bus.id_valid), 32'd0);
    check("idle_id_inst",  bus.id_inst,       32'h0000_0013);

    // streaming with decode always ready
    bus.id_ready = 1'b1;
    offer(1'b1, 32'h0);
    cyc();
    check("stream0_valid", 32'(bus.id_valid), 32'd1);
    check("stream0_pc",    bus.id_pc,         32'h0);
    check("stream0_inst",  bus.id_inst,       32'hA5A5_0000);
    offer(1'b1, 32'h4);
    cyc();
    check("stream1_pc",    bus.id_pc,         32'h4);
    check("stream1_count", 32'(bus.count),    32'd1);
    offer(1'b1, 32'h8);
    cyc();
    check("stream2_pc",    bus.id_pc,         32'h8);
    check("stream2_inst",  bus.id_inst,       32'hA5A5_0008);
    check("stream2_count", 32'(bus.count),    32'd1);
    offer(1'b0, 32'h0);
    cyc();
    check("drain_valid", 32'(bus.id_valid), 32'd0);
    check("drain_inst",  bus.id_inst,       32'h0000_0013);
    check("drain_pc",    bus.id_pc,         32'h0);

    // backpressure fills the queue
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h100);
    cyc();
    offer(1'b1, 32'h104);
    cyc();
    check("bp_count",       32'(bus.count),       32'd2);
    check("bp_fetch_ready", 32'(bus.fetch_ready), 32'd0);
    check("bp_pc",          bus.id_pc,            32'h100);
    offer(1'b1, 32'h108);
    cyc();
    check("bp_hold_pc",    bus.id_pc,      32'h100);
    check("bp_hold_count", 32'(bus.count), 32'd2);

    // full with simultaneous pop: pop only, offered word taken next cycle
    bus.id_ready = 1'b1;
    cyc();
    check("fullpop_count",       32'(bus.count),       32'd1);
    check("fullpop_pc",          bus.id_pc,            32'h104);
    check("fullpop_fetch_ready", 32'(bus.fetch_ready), 32'd1);
    bus.id_ready = 1'b0;
    cyc();
    check("late_accept_count", 32'(bus.count), 32'd2);
    check("late_accept_pc",    bus.id_pc,      32'h104);

    // flush with a same-cycle fetch
    offer(1'b1, 32'h200);
    bus.flush = 1'b1;
    cyc();
    check("flush_count", 32'(bus.count),    32'd0);
    check("flush_valid", 32'(bus.id_valid), 32'd0);
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    offer(1'b0, 32'h0);
    cyc();
    check("flush_drop_valid", 32'(bus.id_valid), 32'd0);
    check("flush_drop_pc",    bus.id_pc,         32'h0);
    offer(1'b1, 32'h300);
    cyc();
    check("post_flush_pc", bus.id_pc, 32'h300);
    offer(1'b0, 32'h0);
    cyc();
    check("post_flush_empty", 32'(bus.count), 32'd0);

    // wrap-around: 5 entries, alternating decode readiness
    next_k = 0;
    for (int c = 0; c < 40 && popped.size() < 5; c++) begin
      offer(next_k < 5, 32'h400 + 32'(next_k) * 4);
      bus.id_ready = c[0];
      #1;
      acc = bus.fetch_valid && (q.size() < 2);
      pop = (q.size() > 0) && bus.id_ready;
      if (pop) popped.push_back(q.pop_front());
      if (acc) begin
        q.push_back(bus.fetch_pc);
        next_k++;
      end
      cyc();
      check("wrap_count", 32'(bus.count), 32'(q.size()));
      if (q.size() > 0) check("wrap_head", bus.id_pc, q[0]);
    end
    check("wrap_done", 32'(popped.size()), 32'd5);
    for (int i = 0; i < popped.size(); i++) begin
      check("wrap_order", popped[i], 32'h400 + 32'(i) * 4);
    end

    // reset mid-stream behaves like a flush
    bus.id_ready = 1'b0;
    offer(1'b1, 32'h500);
    cyc();
    rst = 1'b1;
    offer(1'b0, 32'h0);
    cyc();
    check("midrst_count", 32'(bus.count),    32'd0);
    check("midrst_valid", 32'(bus.id_valid), 32'd0);
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
